// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
package serial_sub_pkg;

  // Sequencer states; encoding is fixed so debug probes read consistent values.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit-counter width: enough to index every operand bit (0..width-1).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - one-bit full subtractor cell
module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic bout
);

  // Difference is the three-way parity; borrow when b+c exceeds a.
  assign diff = a ^ b ^ c;
  assign bout = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - LSB-first bit-serial subtract sequencer around full_sub
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] diff_next;

  full_sub u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (borrow),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // Result bits enter at the top, so after WIDTH steps bit 0 has reached the LSB.
  assign diff_next = {cell_diff, diff_sr[WIDTH-1:1]};

  // Sequencer: operand capture, one bit per cycle in RUN, registered result on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      zero    <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            borrow  <= bin;
            diff_sr <= '0;
            cnt     <= '0;
            state   <= RUN;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= diff_next;
          borrow  <= cell_bout;
          cnt     <= cnt + CW'(1);
          // The last bit is processed now, so the outputs take the post-shift values.
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= diff_next;
            bout  <= cell_bout;
            zero  <= (diff_next == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl at WIDTH 8 and 4
module tb_serial_sub_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8, start8, bin8, busy8, done8, bout8, zero8;
  logic [7:0] a8, b8, diff8;
  logic       rst4, start4, bin4, busy4, done4, bout4, zero4;
  logic [3:0] a4, b4, diff4;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_done8 = 0;
  exp_t sb8[$];
  exp_t sb4[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops one expected result; busy must be low alongside it.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      n_done8++;
      check("excl8", {31'd0, busy8}, 32'd0);
      if (sb8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done8: unexpected done, diff=0x%0h", diff8);
      end else begin
        e = sb8.pop_front();
        check("diff8", {24'd0, diff8}, {24'd0, e.diff});
        check("bout8", {31'd0, bout8}, {31'd0, e.bout});
        check("zero8", {31'd0, zero8}, {31'd0, e.zero});
      end
    end
    if (done4) begin
      check("excl4", {31'd0, busy4}, 32'd0);
      if (sb4.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done4: unexpected done, diff=0x%0h", diff4);
      end else begin
        e = sb4.pop_front();
        check("diff4", {28'd0, diff4}, {28'd0, e.diff[3:0]});
        check("bout4", {31'd0, bout4}, {31'd0, e.bout});
        check("zero4", {31'd0, zero4}, {31'd0, e.zero});
      end
    end
  end

  // One WIDTH=8 operation from idle: checks latency and the number of busy cycles.
  task automatic run8(input vec_t v);
    int c;
    int nbusy;
    exp_t e;
    @(negedge clk);
    a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1;
    e.diff = v.diff; e.bout = v.bout; e.zero = v.zero;
    sb8.push_back(e);
    c = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1) start8 = 1'b0;
      if (busy8) nbusy++;
    end while (!done8 && c < 30);
    check("latency8", c, 9);
    check("busycnt8", nbusy, 8);
  endtask

  initial begin
    int c;
    int d;
    int base;
    exp_t e;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_diff", {24'd0, diff8}, 32'd0);
    check("rst_bout", {31'd0, bout8}, 32'd0);
    check("rst_zero", {31'd0, zero8}, 32'd0);
    rst8 = 1'b0;
    rst4 = 1'b0;

    // Table-driven single operations; the last entry (FF-FF) leaves zero set.
    for (int i = 0; i < 8; i++) run8(tbl[i]);

    // Result holds through idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_diff", {24'd0, diff8}, 32'd0);
      check("hold_zero", {31'd0, zero8}, 32'd1);
      check("hold_busy", {31'd0, busy8}, 32'd0);
    end

    // Start pulse in the middle of a run must be ignored.
    base = n_done8;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    e.diff = 8'h0F; e.bout = 1'b0; e.zero = 1'b0;
    sb8.push_back(e);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      start8 = 1'b0;
      if (c == 3) begin
        a8 = 8'h55; b8 = 8'h22; bin8 = 1'b1; start8 = 1'b1;
      end
    end while (!done8 && c < 30);
    check("ign_latency", c, 9);
    repeat (15) @(negedge clk);
    check("ign_ndone", n_done8 - base, 1);

    // Reset in the middle of a run discards the operation.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    sb8.delete();
    base = n_done8;
    @(negedge clk);
    rst8 = 1'b0;
    check("mrst_busy", {31'd0, busy8}, 32'd0);
    check("mrst_done", {31'd0, done8}, 32'd0);
    check("mrst_diff", {24'd0, diff8}, 32'd0);
    repeat (15) @(negedge clk);
    check("mrst_ndone", n_done8 - base, 0);
    run8('{8'hC8, 8'h37, 1'b0, 8'h91, 1'b0, 1'b0});

    // WIDTH=4 exhaustive with start held high: a result every 5 cycles.
    for (int i = 0; i < 512; i++) begin
      if (i > 0) begin
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!done4 && c < 20);
        check("period4", c, 5);
      end else begin
        @(negedge clk);
      end
      a4 = 4'(i >> 5); b4 = 4'(i >> 1); bin4 = i[0];
      d = int'(a4) - int'(b4) - int'(bin4);
      e.diff = 8'(d & 15); e.bout = (d < 0); e.zero = ((d & 15) == 0);
      sb4.push_back(e);
      start4 = 1'b1;
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done4 && c < 20);
    check("period4", c, 5);
    start4 = 1'b0;
    repeat (10) @(negedge clk);
    check("sb4_empty", sb4.size(), 0);
    check("sb8_empty", sb8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction sequencer built around the team's one-bit `full_sub` cell. It accepts two WIDTH-bit operands and a borrow-in on a start pulse. It then steps the single `full_sub` instance through the operand bits LSB-first, one bit per clock, and returns the WIDTH-bit difference and final borrow with a one-cycle done pulse. It is the area-minimal subtract unit for control-path arithmetic where throughput is not critical.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in to bit 0; captured on accepted start.
- busy  output  1  high while a subtraction is in progress (state RUN).
- done  output  1  single-cycle pulse; diff/bout/zero are valid in that cycle.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out of bit WIDTH-1 (1 when a < b + bin, unsigned).
- zero  output  1  high when diff == 0; updated together with diff.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches a, b and bin into operand shift registers, clears the bit counter and goes to RUN. start=0 stays in IDLE.
- RUN, each cycle:
  - `full_sub` receives a_sr[0], b_sr[0] and borrow flop; its difference bit shifts into diff_sr MSB-side.
  - The borrow flop loads the cell's borrow-out.
  - a_sr and b_sr shift right by one; the counter increments.
- RUN exit: when the counter reaches WIDTH-1, the last bit is processed that cycle. Next state is DONE.
- DONE, one cycle:
  - done=1; diff=diff_sr, bout=borrow flop, zero=(diff_sr==0).
  - start=1 here is accepted exactly as in IDLE (next state RUN); otherwise next state is IDLE.
- Outputs diff/bout/zero are registered. They hold their last result through IDLE and RUN until the next DONE overwrites them.
- start while busy=1 is ignored: no queuing and no effect on the running operation.
- Operand inputs are don't-care except in the cycle start is accepted.
- Arithmetic: pure unsigned, modulo 2^WIDTH. Signed interpretation is the consumer's concern; bout is not an overflow flag.
- Reset, including mid-RUN:
  - State goes to IDLE; busy=0, done=0.
  - diff=0, bout=0, zero=0; counter, borrow flop and shift registers cleared.
  - Any in-flight operation is discarded, and no done is produced for it.
  - rst has priority over start in the same cycle.

## Timing
- Accepted start at edge k: busy=1 for cycles k+1 … k+WIDTH. done=1 in cycle k+WIDTH+1 only.
- Latency from start to done: WIDTH+1 cycles.
- Back-to-back start: with start held high continuously, a new operation begins every WIDTH+1 cycles. done for op n and busy for op n+1 are never high together.
- busy and done are mutually exclusive in every cycle.
- Reset values: busy=0, done=0, diff=0, bout=0, zero=0; first accepted start is the first edge after rst deasserts.

## Structure
- Package serial_sub_pkg holds:
  - the state typedef, encoded IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - a localparam function for counter width, $clog2(WIDTH).
- A single sub-module instance: `full_sub` (ports a, b, c, diff, bout). It is used unchanged as the bit cell; no arithmetic is duplicated in the controller.
- Everything else (FSM, counter, shift registers, borrow flop, output registers) stays in serial_sub_ctrl.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0 -> busy cycles 1–8, done at cycle 9, diff=0x02, bout=0, zero=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0, zero=1; outputs hold through the following 5 idle cycles.
- Second start pulse at cycle 4 of a running op (a=0x10, b=0x01) -> ignored; done still at cycle 9 with diff=0x0F, and exactly one done pulse.
- rst asserted at cycle 5 of a running op -> next cycle busy=0, done=0, diff=0; no done follows; a new start after rst gives a correct result.
- WIDTH=4, exhaustive a, b, bin (512 cases) with start held high: compare against the (a-b-bin) mod 16 reference model and borrow.
- Also check that a done occurs every 5 cycles and that busy and done never overlap.
